// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for one side of the dual-port RAM.
// The bus master drives the command half and the memory drives the response half.
interface onchip_memory_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, read, write, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, read, write, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, pipelined reads,
// optional zero-fill walk after reset and s1-wins write-collision resolution.
module onchip_memory_dp #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 15,
    parameter int DEPTH          = 29499,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reset_req,
    input  logic                 clken,
    onchip_memory_dp_if.slave    s1,
    onchip_memory_dp_if.slave    s2,
    output logic                 busy,
    output logic                 collision
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;
    localparam state_t INIT_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : READY;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              en;
    logic              wait_req;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] addr  [2];
    logic [BE_W-1:0]   be    [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        cs, rd, wr, in_rng;
    logic [1:0]        rd_acc, wr_ok, wr_en;
    logic              coll;

    logic [1:0]        vld_p0, vld_p1, rdv, last_vld;
    logic [DATA_W-1:0] rd_p0    [2];
    logic [DATA_W-1:0] rd_p1    [2];
    logic [DATA_W-1:0] last_data[2];
    logic [DATA_W-1:0] rd_out   [2];

    assign en       = clken & ~reset_req;
    assign busy     = (state == CLEAR);
    assign wait_req = busy | ~en;

    assign s1.waitrequest   = wait_req;
    assign s2.waitrequest   = wait_req;
    assign s1.readdata      = rd_out[0];
    assign s2.readdata      = rd_out[1];
    // The valid flag is held through a stall, so it is masked rather than lost.
    assign s1.readdatavalid = rdv[0] & en;
    assign s2.readdatavalid = rdv[1] & en;

    always_comb begin
        addr[0]  = s1.address;    addr[1]  = s2.address;
        be[0]    = s1.byteenable; be[1]    = s2.byteenable;
        wdata[0] = s1.writedata;  wdata[1] = s2.writedata;
        cs       = {s2.chipselect, s1.chipselect};
        rd       = {s2.read, s1.read};
        wr       = {s2.write, s1.write};
        for (int i = 0; i < 2; i++) begin
            in_rng[i] = 32'(addr[i]) < DEPTH;
        end
        // Write beats read on the same port; reads never stall on a write.
        rd_acc = cs & rd & ~wr & {2{~wait_req}};
        wr_ok  = cs & wr & {2{~wait_req}} & in_rng;
        coll   = wr_ok[0] & wr_ok[1] & (addr[0] == addr[1]);
        wr_en  = {wr_ok[1] & ~coll, wr_ok[0]};
        last_vld = (READ_LATENCY == 1) ? vld_p0 : vld_p1;
        for (int i = 0; i < 2; i++) begin
            last_data[i] = (READ_LATENCY == 1) ? rd_p0[i] : rd_p1[i];
        end
    end

    // Stage p0: array read (old data on same-cycle writes), p1: optional extra stage
    always_ff @(posedge clk) begin
        if (busy && en) begin
            mem[clr_cnt] <= '0;
        end
        for (int i = 0; i < 2; i++) begin
            if (rd_acc[i]) begin
                rd_p0[i] <= in_rng[i] ? mem[addr[i]] : '0;
            end
            if (en && vld_p0[i]) begin
                rd_p1[i] <= rd_p0[i];
            end
            for (int b = 0; b < BE_W; b++) begin
                if (wr_en[i] && be[i][b]) begin
                    mem[addr[i]][8*b +: 8] <= wdata[i][8*b +: 8];
                end
            end
        end
    end

    // Control: FSM, clear walk, valid pipeline, output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT_STATE;
            clr_cnt   <= '0;
            vld_p0    <= '0;
            vld_p1    <= '0;
            rdv       <= '0;
            collision <= 1'b0;
            rd_out[0] <= '0;
            rd_out[1] <= '0;
        end else begin
            collision <= coll;
            if (en) begin
                if (state == CLEAR) begin
                    if (clr_cnt == LAST_ADDR) begin
                        state <= READY;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                vld_p0 <= rd_acc;
                vld_p1 <= vld_p0;
                rdv    <= last_vld;
                for (int i = 0; i < 2; i++) begin
                    if (last_vld[i]) begin
                        rd_out[i] <= last_data[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench for onchip_memory_dp: clear walk, byte writes, collisions,
// read-during-write, stalled burst reads, reset restart and out-of-range access.
module tb_onchip_memory_dp;
    logic clk = 1'b0;
    logic reset, reset_req, clken;
    logic busy, collision;
    int   checks   = 0;
    int   failures = 0;

    onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(8)) s1_bus();
    onchip_memory_dp_if #(.DATA_W(32), .ADDR_W(8)) s2_bus();

    onchip_memory_dp #(
        .DATA_W(32), .ADDR_W(8), .DEPTH(200), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1(s1_bus), .s2(s2_bus), .busy(busy), .collision(collision)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input int port, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
        if (port == 1) begin
            s1_bus.chipselect = 1; s1_bus.write = 1; s1_bus.address = a;
            s1_bus.writedata = d; s1_bus.byteenable = b;
        end else begin
            s2_bus.chipselect = 1; s2_bus.write = 1; s2_bus.address = a;
            s2_bus.writedata = d; s2_bus.byteenable = b;
        end
        tick();
        s1_bus.chipselect = 0; s1_bus.write = 0;
        s2_bus.chipselect = 0; s2_bus.write = 0;
    endtask

    task automatic wait_valid(input int port, output logic [31:0] d, output int lat);
        lat = 0;
        while (!((port == 1) ? s1_bus.readdatavalid : s2_bus.readdatavalid) && lat < 10) begin
            tick();
            lat++;
        end
        d = (port == 1) ? s1_bus.readdata : s2_bus.readdata;
    endtask

    task automatic do_read(input int port, input logic [7:0] a, output logic [31:0] d, output int lat);
        if (port == 1) begin
            s1_bus.chipselect = 1; s1_bus.read = 1; s1_bus.address = a;
        end else begin
            s2_bus.chipselect = 1; s2_bus.read = 1; s2_bus.address = a;
        end
        tick();
        s1_bus.chipselect = 0; s1_bus.read = 0;
        s2_bus.chipselect = 0; s2_bus.read = 0;
        wait_valid(port, d, lat);
    endtask

    task automatic count_busy(output int n, output logic wait_ok);
        n = 0;
        wait_ok = 1'b1;
        while (busy && n < 1000) begin
            if (!(s1_bus.waitrequest && s2_bus.waitrequest)) wait_ok = 1'b0;
            tick();
            n++;
        end
    endtask

    logic [31:0] d;
    int          lat, n, idx, got, stall_pulses;
    logic        wait_ok, stall;
    logic [31:0] got_data [16];

    initial begin
        reset = 1; reset_req = 0; clken = 1;
        s1_bus.chipselect = 0; s1_bus.read = 0; s1_bus.write = 0;
        s1_bus.address = '0; s1_bus.byteenable = '0; s1_bus.writedata = '0;
        s2_bus.chipselect = 0; s2_bus.read = 0; s2_bus.write = 0;
        s2_bus.address = '0; s2_bus.byteenable = '0; s2_bus.writedata = '0;

        // 1: reset values, clear walk length, cleared contents
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_wait", 32'({s1_bus.waitrequest, s2_bus.waitrequest}), 32'd3);
        check("rst_rdv", 32'({s1_bus.readdatavalid, s2_bus.readdatavalid}), 32'd0);
        check("rst_rdata", s1_bus.readdata | s2_bus.readdata, 32'd0);
        check("rst_coll", 32'(collision), 32'd0);
        reset = 0;
        count_busy(n, wait_ok);
        check("clear_len", 32'(n), 32'd200);
        check("clear_wait", 32'(wait_ok), 32'd1);
        check("ready_wait", 32'(s1_bus.waitrequest), 32'd0);
        do_read(1, 8'd0, d, lat);   check("clr_rd0", d, 32'd0);
        check("clr_lat", 32'(lat), 32'd2);
        do_read(1, 8'd99, d, lat);  check("clr_rd99", d, 32'd0);
        do_read(2, 8'd199, d, lat); check("clr_rd199", d, 32'd0);

        reset_req = 1; #1;
        check("rreq_wait", 32'(s2_bus.waitrequest), 32'd1);
        reset_req = 0;

        // 2: byte-lane write merge
        do_write(1, 8'd5, 32'hDEADBEEF, 4'hF);
        do_write(1, 8'd5, 32'h000000AA, 4'h1);
        do_read(2, 8'd5, d, lat);
        check("be_merge", d, 32'hDEADBEAA);
        check("be_lat", 32'(lat), 32'd2);

        // read+write together: write wins, no valid
        s1_bus.read = 1;
        do_write(1, 8'd9, 32'h00000077, 4'hF);
        s1_bus.read = 0;
        wait_valid(1, d, lat);
        check("rw_novalid", 32'(lat), 32'd10);
        do_read(1, 8'd9, d, lat);
        check("rw_wrote", d, 32'h00000077);

        // 3: same-address write collision
        s1_bus.chipselect = 1; s1_bus.write = 1; s1_bus.address = 8'd7;
        s1_bus.writedata = 32'h11111111; s1_bus.byteenable = 4'hF;
        s2_bus.chipselect = 1; s2_bus.write = 1; s2_bus.address = 8'd7;
        s2_bus.writedata = 32'h22222222; s2_bus.byteenable = 4'hF;
        check("coll_pre", 32'(collision), 32'd0);
        tick();
        s1_bus.chipselect = 0; s1_bus.write = 0;
        s2_bus.chipselect = 0; s2_bus.write = 0;
        check("coll_pulse", 32'(collision), 32'd1);
        tick();
        check("coll_end", 32'(collision), 32'd0);
        do_read(2, 8'd7, d, lat);
        check("coll_data", d, 32'h11111111);

        // 4: mixed-port read-during-write returns old data
        s1_bus.chipselect = 1; s1_bus.write = 1; s1_bus.address = 8'd3;
        s1_bus.writedata = 32'h00000055; s1_bus.byteenable = 4'hF;
        s2_bus.chipselect = 1; s2_bus.read = 1; s2_bus.address = 8'd3;
        tick();
        s1_bus.chipselect = 0; s1_bus.write = 0;
        s2_bus.chipselect = 0; s2_bus.read = 0;
        wait_valid(2, d, lat);
        check("rdw_old", d, 32'd0);
        check("rdw_nocoll", 32'(collision), 32'd0);
        do_read(2, 8'd3, d, lat);
        check("rdw_new", d, 32'h00000055);

        // 5: pipelined burst with a 3-cycle clken stall
        for (int i = 0; i < 10; i++) do_write(1, 8'(i), 32'h100 + 32'(i), 4'hF);
        idx = 0; got = 0; stall_pulses = 0; wait_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            stall = (c >= 4 && c < 7);
            clken = !stall;
            s1_bus.chipselect = (idx < 10);
            s1_bus.read       = (idx < 10);
            s1_bus.address    = 8'(idx);
            #1;
            if (stall) begin
                if (!s1_bus.waitrequest) wait_ok = 1'b0;
                if (s1_bus.readdatavalid) stall_pulses++;
            end else if (s1_bus.readdatavalid && got < 16) begin
                got_data[got] = s1_bus.readdata;
                got++;
            end
            if (!s1_bus.waitrequest && idx < 10) idx++;
            tick();
        end
        clken = 1; s1_bus.chipselect = 0; s1_bus.read = 0;
        check("burst_count", 32'(got), 32'd10);
        check("burst_stall_rdv", 32'(stall_pulses), 32'd0);
        check("burst_stall_wait", 32'(wait_ok), 32'd1);
        for (int j = 0; j < 10; j++) check($sformatf("burst_d%0d", j), got_data[j], 32'h100 + 32'(j));

        // 6: read in flight at reset, restart of the clear walk, out-of-range access
        s1_bus.chipselect = 1; s1_bus.read = 1; s1_bus.address = 8'd1;
        tick();
        s1_bus.chipselect = 0; s1_bus.read = 0;
        reset = 1;
        tick();
        reset = 0;
        check("rst_rdata2", s1_bus.readdata, 32'd0);
        lat = 0;
        for (int k = 0; k < 4; k++) begin
            if (s1_bus.readdatavalid) lat++;
            tick();
        end
        check("rst_flush", 32'(lat), 32'd0);
        repeat (115) tick();
        check("mid_busy", 32'(busy), 32'd1);
        reset = 1;
        tick();
        reset = 0;
        count_busy(n, wait_ok);
        check("restart_len", 32'(n), 32'd200);
        do_read(1, 8'd9, d, lat);
        check("restart_zero", d, 32'd0);
        do_write(2, 8'd250, 32'hCAFEF00D, 4'hF);
        do_read(2, 8'd250, d, lat);
        check("oor_read", d, 32'd0);
        check("oor_lat", 32'(lat), 32'd2);
        do_read(1, 8'd50, d, lat);
        check("oor_alias50", d, 32'd0);
        do_read(1, 8'd122, d, lat);
        check("oor_alias122", d, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onchip_memory_dp.md
# onchip_memory_dp

Parametrised true-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2). It adds pipelined reads with `readdatavalid`, `waitrequest` flow control, optional zero-fill after reset, and write-collision resolution. It replaces the fixed 32-bit single-port SoC memory and serves the Nios II data master on s1 and a DMA/video engine on s2.

## Interface
- `DATA_W`, 32: data width in bits; multiple of 8.
- `ADDR_W`, 15: word-address width.
- `DEPTH`, 29499: number of words; must satisfy `DEPTH <= 2**ADDR_W`.
- `READ_LATENCY`, 1: cycles from read accept to data; legal values are 1 and 2.
- `CLEAR_ON_RESET`, 1: when 1, zero every word after reset.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `reset_req`  in  1  when high, stalls both ports, same effect as `clken` low.
- `clken`  in  1  global clock enable.
- `sN_address`  in  ADDR_W  word address (N = 1, 2).
- `sN_chipselect`, `sN_read`, `sN_write`  in  1  Avalon command strobes.
- `sN_byteenable`  in  DATA_W/8  byte lane enables for writes.
- `sN_writedata`  in  DATA_W  write data.
- `sN_readdata`  out  DATA_W  read data.
- `sN_readdatavalid`  out  1  one-cycle pulse qualifying `sN_readdata`.
- `sN_waitrequest`  out  1  command not accepted this cycle.
- `busy`  out  1  clear sequence in progress.
- `collision`  out  1  one-cycle pulse: an s2 write was dropped.

## Operation
- FSM states:
  - CLEAR: entered on reset when `CLEAR_ON_RESET=1`. A counter walks addresses 0..DEPTH-1 and writes all-zero through port A, one word per enabled cycle. The transition to READY occurs in the cycle after address DEPTH-1 is written.
  - READY: entered on reset when `CLEAR_ON_RESET=0`. Both ports serve Avalon commands.
- Effective enable `en = clken & ~reset_req`.
- Accept rule: a command is accepted when `chipselect & (read|write) & ~waitrequest`.
- `sN_waitrequest = busy | ~en`; registered and combinational forms are both acceptable if the accept rule holds.
- Read and write asserted together on a port: the write takes priority and the read is ignored (no `readdatavalid`).
- Write: updates only the lanes whose `byteenable` bit is 1.
- Address >= DEPTH:
  - write: dropped.
  - read: returns zero with normal `readdatavalid`.
- Same-port read after write: a read the cycle after a write sees the new data.
- Mixed-port read-during-write, same address in the same cycle: the reader returns OLD data.
- Both ports write the same address in the same cycle: s1 wins, the s2 write is fully discarded, and `collision` pulses for one cycle. Disjoint writes proceed independently.
- Read pipeline: per port, a shift register of depth `READ_LATENCY` carries valid bits. While `en=0` it holds (no advance, no `readdatavalid` pulse). Data is held at the output until the next valid read.
- Reset:
  - All state restarts synchronously: FSM, clear counter, and valid pipelines are flushed.
  - Memory contents are not cleared by reset alone; only the CLEAR walk zeroes them.
  - Reset during CLEAR restarts the walk from address 0.
  - Reads in flight at reset produce no `readdatavalid`.

## Timing
- Reset values:
  - `sN_readdata` = 0, `sN_readdatavalid` = 0, `collision` = 0.
  - `busy` = `CLEAR_ON_RESET`; `sN_waitrequest` = 1 while busy, else `~en`.
- Read accepted at edge k: `readdatavalid` is high in the cycle after edge k+`READ_LATENCY` (counted in enabled cycles).
- Throughput: one command per port per enabled cycle, with back-to-back reads fully pipelined.
- CLEAR duration: exactly DEPTH enabled cycles after reset deasserts. `busy` falls on the following edge.
- `collision` pulses in the cycle after the colliding accept edge.

## Test plan
All scenarios use `DATA_W=32`, `ADDR_W=8`, `DEPTH=200`, `READ_LATENCY=2`, `CLEAR_ON_RESET=1`.
1. Release reset → `busy` high for 200 cycles, `waitrequest` high on both ports throughout; then reads of addresses 0, 99 and 199 return 0.
2. s1 writes 0xDEADBEEF to address 5 with byteenable 0xF, then 0x000000AA with byteenable 0x1 → s2 reads 0xDEADBEAA; `readdatavalid` asserts exactly 2 cycles after accept.
3. Same cycle: s1 writes 0x11111111 and s2 writes 0x22222222, both to address 7 → `collision` pulses once; readback is 0x11111111.
4. s1 writes 0x55 to address 3 while s2 reads address 3 in the same cycle (old value 0) → s2 gets 0; the next s2 read returns 0x55.
5. Back-to-back s1 reads of addresses 0..9 with `clken` dropped for 3 cycles mid-burst → 10 in-order `readdatavalid` pulses, none during the stall, and `waitrequest` high during the stall.
6. Assert reset at clear count 120 → walk restarts; `busy` lasts 200 cycles from release. Also verify a read to address 250 returns 0 and a write to address 250 has no effect.
